tile_write_back: RTL

// Write-back engine: the store-side counterpart of the RAM tile/vector fetch.

---
 rtl/tile_write_back.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tile_write_back.sv
`default_nettype none
// ============================================================================
// Module      : tile_write_back
// Description : Latches an M x N result tile on start and streams it row-major
//               into the RAM single-word write port, pausing while grant is low.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_write_back #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int DIM    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    input  logic [ADDR_W-1:0]    tile_M,
    input  logic [ADDR_W-1:0]    tile_N,
    input  logic [ADDR_W-1:0]    row_stride,
    input  logic [ADDR_W-1:0]    base_address,
    input  logic [DATA_W-1:0]    tile_in [DIM][DIM],
    input  logic                 grant,
    output logic                 write_block,
    output logic [ADDR_W-1:0]    address_block,
    output logic [DATA_W-1:0]    wr_data
);

    localparam int              c_IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [ADDR_W-1:0] c_DIM_A = ADDR_W'(DIM);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]          r_state, w_state_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_busy,  w_busy_nxt;
    logic                r_done,  w_done_nxt;
    logic                r_wr,    w_wr_nxt;
    logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic [DATA_W-1:0]   r_data,  w_data_nxt;
    logic [c_IDX_W-1:0]  r_row,   w_row_nxt;
    logic [c_IDX_W-1:0]  r_col,   w_col_nxt;
    logic [ADDR_W-1:0]   r_row_addr, w_row_addr_nxt;
    logic [c_IDX_W-1:0]  r_last_row;
    logic [c_IDX_W-1:0]  r_last_col;
    logic [ADDR_W-1:0]   r_stride;
    logic [DATA_W-1:0]   r_tile [DIM][DIM];

    logic                w_accept;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_m_clip;
    logic [ADDR_W-1:0]   w_n_clip;

    assign w_accept = (r_state == c_IDLE) && r_ready && start;
    assign w_empty  = (tile_M == '0) || (tile_N == '0);
    assign w_m_clip = (tile_M > c_DIM_A) ? c_DIM_A : tile_M;
    assign w_n_clip = (tile_N > c_DIM_A) ? c_DIM_A : tile_N;

    // r_row_addr tracks base + row*stride incrementally, so no multiplier is needed.
    always_comb begin
        w_state_nxt    = r_state;
        w_ready_nxt    = r_ready;
        w_done_nxt     = 1'b0;
        w_wr_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_row_addr_nxt = r_row_addr;
        case (r_state)
            c_IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_ready_nxt    = 1'b0;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                    w_row_addr_nxt = base_address;
                    w_state_nxt    = w_empty ? c_DONE : c_WRITE;
                end
            end
            c_WRITE: begin
                if (grant) begin
                    w_wr_nxt   = 1'b1;
                    w_addr_nxt = r_row_addr + ADDR_W'(r_col);
                    w_data_nxt = r_tile[r_row][r_col];
                    if (r_col == r_last_col) begin
                        w_col_nxt      = '0;
                        w_row_nxt      = r_row + c_IDX_W'(1);
                        w_row_addr_nxt = r_row_addr + r_stride;
                        if (r_row == r_last_row) begin
                            w_state_nxt = c_DONE;
                        end
                    end else begin
                        w_col_nxt = r_col + c_IDX_W'(1);
                    end
                end
            end
            c_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
        w_busy_nxt = ~w_ready_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_row_addr <= '0;
            r_last_row <= '0;
            r_last_col <= '0;
            r_stride   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wr       <= w_wr_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_row_addr <= w_row_addr_nxt;
            if (w_accept) begin
                r_stride   <= row_stride;
                r_last_row <= c_IDX_W'(w_m_clip - ADDR_W'(1));
                r_last_col <= c_IDX_W'(w_n_clip - ADDR_W'(1));
            end
        end
    end

    // Tile storage is pure datapath; contents only matter after a start.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tile <= tile_in;
        end
    end

    assign ready         = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign write_block   = r_wr;
    assign address_block = r_addr;
    assign wr_data       = r_data;

endmodule
`default_nettype wire
